// File: rtl/sensor_stream_pkg.sv
// Shared encodings and constants for the sensor frame streamer.
package sensor_stream_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_STOP   = 2'b00,
    MODE_SINGLE = 2'b01,
    MODE_STREAM = 2'b10
  } mode_t;

  localparam logic [15:0] CMD_STOP   = 16'hC000;
  localparam logic [15:0] CMD_SINGLE = 16'hC001;
  localparam logic [15:0] CMD_STREAM = 16'hC002;
  localparam logic [7:0]  HDR_SYNC   = 8'hA5;
endpackage

// File: rtl/snapshot_shifter.sv
// Snapshot register: parallel load, shift out 16 bits per word, most-significant word first.
module snapshot_shifter #(
  parameter int unsigned W  = 64,
  parameter int unsigned NP = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic [15:0]  word,
  output logic         last
);
  localparam int unsigned CW = $clog2(NP + 1);

  logic [W-1:0]  r_sh;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_sh  <= din;
      r_cnt <= CW'(NP);
    end else if (shift && r_cnt != '0) begin
      r_sh  <= r_sh << 16;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign word = r_sh[W-1 -: 16];
  assign last = (r_cnt == CW'(1));
endmodule

// File: rtl/sensor_frame_streamer.sv
// Captures sensor snapshots and streams them to the SPI slave as
// header / payload / checksum frames; host commands select the mode.
module sensor_frame_streamer
  import sensor_stream_pkg::*;
#(
  parameter int unsigned SENSORS  = 1,
  parameter int unsigned BITWIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [2*SENSORS*BITWIDTH-1:0]   data,
  input  logic                            data_ready,
  output logic                            ack,
  input  logic                            tx_ready,
  output logic                            tx_write,
  output logic [15:0]                     tx_data,
  input  logic                            rx_ready,
  input  logic [15:0]                     rx_data,
  output logic [1:0]                      mode,
  output logic                            busy,
  output logic                            cmd_error
);
  localparam int unsigned PW = BITWIDTH / 16;
  localparam int unsigned NP = 2 * SENSORS * PW;
  localparam int unsigned DW = 2 * SENSORS * BITWIDTH;

  state_t      r_state;
  mode_t       r_mode;
  logic [7:0]  r_seq;
  logic [15:0] r_csum;
  logic        r_ack;
  logic        r_cmd_err;
  logic        r_gap;

  logic        w_capture;
  logic        w_issue;
  logic        w_last;
  logic [15:0] w_sh_word;
  logic [15:0] w_word;

  assign w_capture = (r_state == ST_IDLE) && (r_mode != MODE_STOP) && data_ready;
  // r_gap enforces the two-cycle write spacing and also holds off the header
  // for one cycle after capture, while ack is pulsing.
  assign w_issue   = (r_state != ST_IDLE) && tx_ready && !r_gap;

  always_comb begin
    w_word = '0;
    case (r_state)
      ST_HEADER:  w_word = {HDR_SYNC, r_seq};
      ST_PAYLOAD: w_word = w_sh_word;
      ST_CSUM:    w_word = r_csum;
      default:    w_word = '0;
    endcase
  end

  snapshot_shifter #(.W(DW), .NP(NP)) u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (w_capture),
    .shift (w_issue && (r_state == ST_PAYLOAD)),
    .din   (data),
    .word  (w_sh_word),
    .last  (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_STOP;
      r_seq     <= '0;
      r_csum    <= '0;
      r_ack     <= 1'b0;
      r_cmd_err <= 1'b0;
      r_gap     <= 1'b0;
    end else begin
      r_ack     <= 1'b0;
      r_cmd_err <= 1'b0;
      r_gap     <= w_issue || w_capture;
      case (r_state)
        ST_IDLE: if (w_capture) begin
          r_ack   <= 1'b1;
          r_state <= ST_HEADER;
        end
        ST_HEADER: if (w_issue) begin
          r_csum  <= r_csum + w_word;
          r_state <= ST_PAYLOAD;
        end
        ST_PAYLOAD: if (w_issue) begin
          r_csum <= r_csum + w_word;
          if (w_last) r_state <= ST_CSUM;
        end
        ST_CSUM: if (w_issue) begin
          r_seq   <= r_seq + 8'd1;
          r_csum  <= '0;
          r_state <= ST_IDLE;
          if (r_mode == MODE_SINGLE) r_mode <= MODE_STOP;
        end
        default: r_state <= ST_IDLE;
      endcase
      // Placed after the frame-end logic so a same-cycle command overrides the SINGLE drop.
      if (rx_ready) begin
        case (rx_data)
          CMD_STOP:   r_mode    <= MODE_STOP;
          CMD_SINGLE: r_mode    <= MODE_SINGLE;
          CMD_STREAM: r_mode    <= MODE_STREAM;
          default:    r_cmd_err <= 1'b1;
        endcase
      end
    end
  end

  assign ack       = r_ack;
  assign tx_write  = w_issue;
  assign tx_data   = w_issue ? w_word : 16'h0000;
  assign mode      = r_mode;
  assign busy      = (r_state != ST_IDLE);
  assign cmd_error = r_cmd_err;
endmodule

// File: tb/tb_sensor_frame_streamer.sv
// Scoreboard bench for sensor_frame_streamer (SENSORS=1, BITWIDTH=32, 6-word frames).
module tb_sensor_frame_streamer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data = '0;
  logic        data_ready = 1'b0;
  logic        tx_ready = 1'b0;
  logic        rx_ready = 1'b0;
  logic [15:0] rx_data = '0;
  logic        ack, tx_write, busy, cmd_error;
  logic [15:0] tx_data;
  logic [1:0]  mode;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] log_w[$];
  int   pos = 0;
  int   wr_cnt = 0;
  int   ack_cnt = 0;
  int   hdr0_cnt = 0;
  logic prev_w = 1'b0;
  logic prev_ack = 1'b0;
  logic [7:0] m_seq = '0;
  logic rand_data = 1'b0;

  always #5 clk = ~clk;

  sensor_frame_streamer #(.SENSORS(1), .BITWIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .data_ready (data_ready),
    .ack        (ack),
    .tx_ready   (tx_ready),
    .tx_write   (tx_write),
    .tx_data    (tx_data),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .mode       (mode),
    .busy       (busy),
    .cmd_error  (cmd_error)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference frame: header with running sequence, payload MS word first, 16-bit sum of the rest.
  task automatic push_frame(input logic [63:0] d);
    logic [15:0] sum;
    logic [15:0] w;
    sum = {8'hA5, m_seq};
    exp_q.push_back(sum);
    for (int i = 0; i < 4; i++) begin
      w = d[63 - 16*i -: 16];
      exp_q.push_back(w);
      sum = sum + w;
    end
    exp_q.push_back(sum);
    m_seq = m_seq + 8'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst) m_seq = '0;
    if (ack) begin
      chk("ack_one_cycle", {31'd0, prev_ack}, 32'd0);
      ack_cnt++;
      push_frame(data);
      if (rand_data) data = {$urandom, $urandom};
    end
    prev_ack = ack;
  endtask

  task automatic send_cmd(input logic [15:0] c);
    rx_data  = c;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic wait_acks(input int target, input int max);
    int n = 0;
    while (ack_cnt < target && n < max) begin tick(); n++; end
    if (ack_cnt < target) chk("ack_timeout", ack_cnt, target);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < max) begin tick(); n++; end
    if (busy || exp_q.size() != 0) chk("idle_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_pos(input int p, input int max);
    int n = 0;
    while (!(busy && pos == p) && n < max) begin tick(); n++; end
    if (!(busy && pos == p)) chk("pos_timeout", pos, p);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},      {31'd0, ack},       32'd0);
    chk({tag, "_tx_write"}, {31'd0, tx_write},  32'd0);
    chk({tag, "_tx_data"},  {16'd0, tx_data},   32'd0);
    chk({tag, "_mode"},     {30'd0, mode},      32'd0);
    chk({tag, "_busy"},     {31'd0, busy},      32'd0);
    chk({tag, "_cmd_error"},{31'd0, cmd_error}, 32'd0);
  endtask

  // Monitor: every DUT write is checked against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      exp_q.delete();
      pos = 0;
      prev_w = 1'b0;
    end else begin
      if (tx_write) begin
        chk("tx_ready_at_write", {31'd0, tx_ready}, 32'd1);
        chk("write_spacing", {31'd0, prev_w}, 32'd0);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got %0h expected no write", tx_data);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            bad++;
            $display("FAIL frame_word: got %0h expected %0h", tx_data, e);
          end
        end
        log_w.push_back(tx_data);
        wr_cnt++;
        if (pos == 0 && tx_data == 16'hA500) hdr0_cnt++;
        pos = (pos == 5) ? 0 : pos + 1;
      end
      prev_w = tx_write;
    end
  end

  initial begin
    logic [15:0] gold [6];
    int a0, h0, w0, n;
    gold = '{16'hA500, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h4FAA};

    #3 rst = 1'b0;
    #4 chk_reset_outputs("reset");
    #10 rst = 1'b1;
    tick(); tick();

    // Post-reset STOP mode: the source stalls.
    data_ready = 1'b1;
    repeat (10) tick();
    chk("stop_no_ack", ack_cnt, 0);
    chk("stop_no_write", wr_cnt, 0);
    chk("stop_mode", {30'd0, mode}, 32'd0);

    // Single-shot frame with the known vector.
    data = 64'h1111_2222_3333_4444;
    tx_ready = 1'b1;
    log_w.delete();
    send_cmd(16'hC001);
    chk("single_mode", {30'd0, mode}, 32'd1);
    wait_acks(1, 20);
    wait_idle(100);
    chk("single_len", log_w.size(), 6);
    for (int i = 0; i < 6; i++) chk("single_word", {16'd0, log_w[i]}, {16'd0, gold[i]});
    chk("single_to_stop", {30'd0, mode}, 32'd0);
    repeat (10) tick();
    chk("single_no_reack", ack_cnt, 1);

    // Streaming with random data and random backpressure through a sequence wrap.
    rand_data = 1'b1;
    data = {$urandom, $urandom};
    h0 = hdr0_cnt;
    a0 = ack_cnt;
    send_cmd(16'hC002);
    n = 0;
    while (ack_cnt < a0 + 257 && n < 20000) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    tx_ready = 1'b1;
    chk("stream_frames", ack_cnt, a0 + 257);
    chk("seq_wrap_hdr", hdr0_cnt - h0, 1);

    // Long backpressure mid-payload.
    wait_pos(2, 100);
    tx_ready = 1'b0;
    w0 = wr_cnt;
    repeat (20) tick();
    chk("stall_no_write", wr_cnt, w0);
    tx_ready = 1'b1;

    // STOP mid-payload lets the frame finish.
    wait_pos(3, 100);
    send_cmd(16'hC000);
    a0 = ack_cnt;
    wait_idle(200);
    chk("stop_mode_after", {30'd0, mode}, 32'd0);
    repeat (10) tick();
    chk("stop_no_new_frame", ack_cnt, a0);
    send_cmd(16'h1234);
    chk("cmd_error_pulse", {31'd0, cmd_error}, 32'd1);
    chk("bad_cmd_mode", {30'd0, mode}, 32'd0);
    tick();
    chk("cmd_error_clear", {31'd0, cmd_error}, 32'd0);

    // Reset mid-payload.
    send_cmd(16'hC002);
    wait_pos(2, 100);
    #1 rst = 1'b0;
    #1 chk_reset_outputs("midrst");
    tick();
    rst = 1'b1;
    tick();

    // Fresh SINGLE frame restarts at seq 0; STREAM arriving at frame end wins.
    log_w.delete();
    a0 = ack_cnt;
    send_cmd(16'hC001);
    wait_acks(a0 + 1, 20);
    wait_pos(5, 100);
    rx_data = 16'hC002;
    rx_ready = 1'b1;
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    tick();
    rx_ready = 1'b0;
    chk("post_reset_hdr", {16'd0, log_w[0]}, 32'h0000A500);
    chk("cmd_wins_at_end", {30'd0, mode}, 32'd2);

    send_cmd(16'hC000);
    wait_idle(200);
    chk("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
